// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the hex keypad operand entry path.
//
// Handshake note for this slice: key_valid and start are single-cycle
// strobes with no ready/acknowledge. A consumer must sample them on the
// cycle they are high. key_code is held stable between key_valid strobes.
// start is only raised while div_ready is high, so the divider is never
// started while it is busy.
package keypad_pkg;

  typedef logic [3:0] hex_t;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_t;

  // Key legend indexed [row][column].
  localparam hex_t KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Active-low column drive for each column index.
  localparam logic [3:0] COL_PATTERN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Index of the lowest row line that is pulled low (0 when none is low).
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 active-low keypad: scan-tick divider, row
// synchroniser, press/release debounce FSM and key decode. The FSM state is
// held in the signal named state so it can be observed directly.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 65536,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output hex_t       key_code
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic          any_low;
  logic [1:0]    low_idx;
  scan_state_t   state;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rel_cnt;

  // Free-running divider; tick marks the wrap from SCAN_DIV-1 back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_ONE;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Two-flop synchroniser for the row lines; reset to the all-released level
  // so no phantom press is seen before the first real samples arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign any_low = ~&row_sync;
  assign low_idx = lowest_low(row_sync);
  assign col     = COL_PATTERN[col_idx];

  // Scan / debounce / wait-for-release FSM, advanced only on scan ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cnt       <= '0;
      rel_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              row_idx <= low_idx;
              cnt     <= CNT_ONE;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end
          DEBOUNCE: begin
            // Column stays frozen; only the originally latched row counts.
            if (any_low && (low_idx == row_idx)) begin
              if (int'(cnt) + 1 >= DEBOUNCE_TICKS) begin
                key_valid <= 1'b1;
                key_code  <= KEY_MAP[row_idx][col_idx];
                rel_cnt   <= '0;
                state     <= PRESSED;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
              state <= SCAN;
            end
          end
          PRESSED: begin
            // Any low row, including a different key, restarts the release count.
            if (!any_low) begin
              if (int'(rel_cnt) + 1 >= DEBOUNCE_TICKS) begin
                rel_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                state   <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + CNT_ONE;
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad-driven operand entry for the restoring divider. Shifts decoded hex
// digits into the dividend or divisor, handles the clear and enter buttons
// and issues a one-cycle start strobe once both operands are committed.
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 65536,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        btn_enter,
  input  logic        btn_clr,
  input  logic        div_ready,
  output logic [3:0]  col,
  output logic [15:0] dividend,
  output logic [15:0] divisor,
  output logic        entry_sel,
  output logic        start,
  output logic        key_valid,
  output hex_t        key_code
);

  logic enter_meta, enter_sync, enter_prev;
  logic clr_meta, clr_sync, clr_prev;
  logic enter_rise, clr_rise;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // Button synchronisers plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_meta <= 1'b0;
      enter_sync <= 1'b0;
      enter_prev <= 1'b0;
      clr_meta   <= 1'b0;
      clr_sync   <= 1'b0;
      clr_prev   <= 1'b0;
    end else begin
      enter_meta <= btn_enter;
      enter_sync <= enter_meta;
      enter_prev <= enter_sync;
      clr_meta   <= btn_clr;
      clr_sync   <= clr_meta;
      clr_prev   <= clr_sync;
    end
  end

  assign enter_rise = enter_sync & ~enter_prev;
  assign clr_rise   = clr_sync & ~clr_prev;

  // Operand registers, entry selection and start strobe; clear beats enter,
  // enter beats a keypress, and a losing event in the same cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend  <= 16'h0000;
      divisor   <= 16'h0000;
      entry_sel <= 1'b0;
      start     <= 1'b0;
    end else begin
      start <= 1'b0;
      if (clr_rise) begin
        if (entry_sel) divisor  <= 16'h0000;
        else           dividend <= 16'h0000;
      end else if (enter_rise) begin
        if (!entry_sel) begin
          entry_sel <= 1'b1;
        end else if (div_ready) begin
          // Operands are left untouched so the divider sees stable inputs.
          start     <= 1'b1;
          entry_sel <= 1'b0;
        end
      end else if (key_valid) begin
        if (entry_sel) divisor  <= {divisor[11:0], key_code};
        else           dividend <= {dividend[11:0], key_code};
      end
    end
  end

endmodule
